// File: rtl/key_event_ctl.sv
// PS/2 scan-code sequencer: make/break/extended prefix FSM, held key levels, press pulses,
// move direction and the jump-charge timer. Optional arrow keys via KEY_EVENT_ARROWS_EN.
module key_event_ctl #(
   parameter int CHARGE_W   = 6,
   parameter int CHARGE_MAX = 63,
   parameter int CHARGE_DIV = 100000,
   parameter int TIMEOUT    = 2000000
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_byte,
   input  logic                rx_valid,
   output logic                key_space,
   output logic                key_left,
   output logic                key_right,
   output logic [2:0]          press_pulse,
   output logic [1:0]          move_dir,
   output logic                jump_valid,
   output logic [CHARGE_W-1:0] jump_charge
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
   localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CHARGE_DIV - 1);
   localparam logic [CHARGE_W-1:0] CHG_MAX  = CHARGE_W'(CHARGE_MAX);
   localparam logic [CHARGE_W-1:0] CHG_PRE  = CHARGE_W'(CHARGE_MAX - 1);
   // Bit order matches press_pulse: [0] left, [1] right, [2] space
   localparam logic [23:0] KEY_CODES = {8'h29, 8'h23, 8'h1C};
   localparam logic [7:0]  BYTE_F0   = 8'hF0;
   localparam logic [7:0]  BYTE_E0   = 8'hE0;

   typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;
   state_t r_state, w_state_next;
   logic [TMO_W-1:0] r_tmo, w_tmo_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_next;
         r_tmo   <= w_tmo_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tmo_next   = r_tmo;
      if (rx_valid) begin
         w_tmo_next = '0;
         case (r_state)
            ST_IDLE: begin
               if (rx_byte == BYTE_F0)      w_state_next = ST_BRK;
               else if (rx_byte == BYTE_E0) w_state_next = ST_EXT;
               else                         w_state_next = ST_IDLE;
            end
            ST_EXT:  w_state_next = (rx_byte == BYTE_F0) ? ST_EXT_BRK : ST_IDLE;
            default: w_state_next = ST_IDLE;
         endcase
      end else if (r_state != ST_IDLE) begin
         // An abandoned prefix returns to IDLE without touching any key
         if (r_tmo == TMO_LAST) begin
            w_state_next = ST_IDLE;
            w_tmo_next   = '0;
         end else begin
            w_tmo_next = r_tmo + 1'b1;
         end
      end
   end

   logic [2:0] w_make_ad, w_brk_ad, r_lvl_ad, w_lvl_ad_next;
   logic [1:0] w_make_ar, w_brk_ar, w_lvl_ar, w_lvl_ar_next;
   logic [2:0] w_make, w_lvl, w_lvl_next;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_key
         assign w_make_ad[gi] = rx_valid && (r_state == ST_IDLE) && (rx_byte == KEY_CODES[gi*8 +: 8]);
         assign w_brk_ad[gi]  = rx_valid && (r_state == ST_BRK)  && (rx_byte == KEY_CODES[gi*8 +: 8]);
      end
   endgenerate

`ifdef KEY_EVENT_ARROWS_EN
   localparam logic [15:0] ARROW_CODES = {8'h74, 8'h6B};
   logic [1:0] r_lvl_ar;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_arrow
         assign w_make_ar[gi] = rx_valid && (r_state == ST_EXT)     && (rx_byte == ARROW_CODES[gi*8 +: 8]);
         assign w_brk_ar[gi]  = rx_valid && (r_state == ST_EXT_BRK) && (rx_byte == ARROW_CODES[gi*8 +: 8]);
      end
   endgenerate

   assign w_lvl_ar_next = (r_lvl_ar | w_make_ar) & ~w_brk_ar;
   assign w_lvl_ar      = r_lvl_ar;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_lvl_ar <= '0;
      else      r_lvl_ar <= w_lvl_ar_next;
   end
`else
   assign w_make_ar     = '0;
   assign w_brk_ar      = '0;
   assign w_lvl_ar      = '0;
   assign w_lvl_ar_next = '0;
`endif

   assign w_lvl_ad_next = (r_lvl_ad | w_make_ad) & ~w_brk_ad;
   assign w_make        = w_make_ad | {1'b0, w_make_ar};
   assign w_lvl         = r_lvl_ad | {1'b0, w_lvl_ar};
   assign w_lvl_next    = w_lvl_ad_next | {1'b0, w_lvl_ar_next};

   logic [1:0]          r_dir, w_dir_next;
   logic [2:0]          r_pulse;
   logic [DIV_W-1:0]    r_div, w_div_next;
   logic [CHARGE_W-1:0] r_charge, w_charge_next, r_jump_charge, w_jump_charge_next;
   logic                r_lock, w_lock_next, r_jump_valid, w_jump_valid_next;

   always_comb begin
      w_dir_next = r_dir;
      if (w_make[0])                         w_dir_next = 2'b01;
      else if (w_make[1])                    w_dir_next = 2'b10;
      else if (r_dir == 2'b01 && !w_lvl_next[0]) w_dir_next = w_lvl_next[1] ? 2'b10 : 2'b00;
      else if (r_dir == 2'b10 && !w_lvl_next[1]) w_dir_next = w_lvl_next[0] ? 2'b01 : 2'b00;
   end

   always_comb begin
      w_div_next         = r_div;
      w_charge_next      = r_charge;
      w_lock_next        = r_lock;
      w_jump_valid_next  = 1'b0;
      w_jump_charge_next = r_jump_charge;
      if (w_brk_ad[2]) begin
         // A break after an auto-fire only re-arms; it never emits a second jump
         w_div_next    = '0;
         w_charge_next = '0;
         if (r_lock) begin
            w_lock_next = 1'b0;
         end else begin
            w_jump_valid_next  = 1'b1;
            w_jump_charge_next = r_charge;
         end
      end else if (w_lvl[2] && !r_lock) begin
         if (r_div == DIV_LAST) begin
            w_div_next = '0;
            if (r_charge == CHG_PRE) begin
               w_jump_valid_next  = 1'b1;
               w_jump_charge_next = CHG_MAX;
               w_charge_next      = '0;
               w_lock_next        = 1'b1;
            end else begin
               w_charge_next = r_charge + 1'b1;
            end
         end else begin
            w_div_next = r_div + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lvl_ad      <= '0;
         r_dir         <= '0;
         r_pulse       <= '0;
         r_div         <= '0;
         r_charge      <= '0;
         r_lock        <= 1'b0;
         r_jump_valid  <= 1'b0;
         r_jump_charge <= '0;
      end else begin
         r_lvl_ad      <= w_lvl_ad_next;
         r_dir         <= w_dir_next;
         r_pulse       <= w_make & ~w_lvl;
         r_div         <= w_div_next;
         r_charge      <= w_charge_next;
         r_lock        <= w_lock_next;
         r_jump_valid  <= w_jump_valid_next;
         r_jump_charge <= w_jump_charge_next;
      end
   end

   assign key_left    = w_lvl[0];
   assign key_right   = w_lvl[1];
   assign key_space   = w_lvl[2];
   assign press_pulse = r_pulse;
   assign move_dir    = r_dir;
   assign jump_valid  = r_jump_valid;
   assign jump_charge = r_jump_charge;
endmodule

// File: doc/key_event_ctl.md
Name: key_event_ctl

Overview:
Sequences the raw PS/2 scan-code byte stream into game-level key state for the player controller. A prefix-tracking FSM resolves make, break (F0) and extended (E0) codes into held levels and one-cycle press pulses for space, left and right. It also runs the jump-charge timer: charge accumulates while space is held and is released as a single jump event. Sits between the PS/2 receiver and the player movement logic.

Parameters:
CHARGE_W, 6, width of the jump charge value
CHARGE_MAX, 63, charge saturation value; reaching it auto-fires the jump (must be <= 2^CHARGE_W-1)
CHARGE_DIV, 100000, clk cycles per charge increment
TIMEOUT, 2000000, idle clk cycles after which a partial prefix sequence is abandoned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_byte  in  8  received scan-code byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
key_space  out  1  space held level
key_left  out  1  left held level
key_right  out  1  right held level
press_pulse  out  3  one-cycle make pulses {space,right,left}
move_dir  out  2  00 none, 01 left, 10 right; last-pressed wins
jump_valid  out  1  one-cycle jump event
jump_charge  out  CHARGE_W  charge attached to jump_valid, held until next jump

Behaviour:
- Reset (rst low, async): all outputs 0, FSM IDLE, counters 0, jump_lock 0.
- Key codes: space 0x29, right 0x23, left 0x1C.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (E0 then F0).
- IDLE: F0->BRK; E0->EXT; key code->make; other->IDLE, no effect.
- BRK: any byte->IDLE; key code->break (clear level).
- EXT: F0->EXT_BRK; any other byte->IDLE (extended make, see optional feature).
- EXT_BRK: any byte->IDLE (extended break).
- Make: level set; press_pulse bit high the cycle after rx_valid only if level was 0 (typematic repeats give no pulse).
- Timeout: in non-IDLE state, counter runs on cycles without rx_valid; reaching TIMEOUT->IDLE, no key change. Reset on each rx_valid.
- move_dir: left make->01, right make->10; releasing the active direction falls to the other if still held, else 00.
- Charge: while key_space=1 and jump_lock=0, divider counts; at CHARGE_DIV-1 it wraps and charge increments, saturating at CHARGE_MAX.
- Space break with jump_lock=0: jump_valid=1 one cycle later, jump_charge=charge before any same-cycle increment; charge and divider clear.
- Charge reaching CHARGE_MAX: jump_valid fires the next cycle with CHARGE_MAX; jump_lock=1; charge cleared. Subsequent space break clears jump_lock, no second jump.
- Space break with charge 0: jump_valid still fires, jump_charge=0.
- rx_valid outside listed codes in any state never alters key levels.
- Reset mid-sequence or mid-charge: immediate return to reset values; no jump emitted.

Optional Feature:
Macro KEY_EVENT_ARROWS_EN. Defined: E0 0x6B (left arrow) and E0 0x74 (right arrow) act as left/right make, E0 F0 0x6B / E0 F0 0x74 as break, OR-ed per direction with A/D sources (level clears only when both sources released). Undefined: all E0 sequences are consumed by the FSM and ignored.

Test Plan:
Reset with rst=0 mid-charge (charge=5) -> all outputs 0, no jump_valid after rst=1.
Bytes 1C, 1C, 1C -> key_left=1, press_pulse=001 once only, move_dir=01.
1C, 23, F0 23 -> move_dir 01->10->01; key_right=0 after break.
CHARGE_DIV=4: 29, hold 20 cycles, F0 29 -> jump_valid one cycle, jump_charge=5, charge then 0.
CHARGE_DIV=2, CHARGE_MAX=3: hold space -> jump_valid with 3 after 6 cycles; no further jump on F0 29; new 29 recharges.
TIMEOUT=10: byte F0 then 12 idle cycles, then 29 -> key_space=1 (treated as make, not break).
